// File: rtl/sc_game_turn_arbiter.sv
// Turn scheduler for the two-player game: grants the shared shift register to one
// player at a time, forwards one move per turn, enforces a per-turn timeout.
module sc_game_turn_arbiter #(
    parameter int TURN_TICKS = 10,
    parameter int TIMER_W    = 4,
    parameter int MOVE_W     = 8
) (
    input  logic               SC_STATEMACHINE_JUG1_CLOCK_50,
    input  logic               SC_STATEMACHINE_JUG1_RESET_InHigh,
    input  logic               tick_In,
    input  logic               startButton_InLow,
    input  logic [1:0]         p1_shiftselection_In,
    input  logic [1:0]         p2_shiftselection_In,
    input  logic               gameover_InHigh,
    output logic [1:0]         shiftselection_Out,
    output logic               clear_OutLow,
    output logic               turn_Out,
    output logic               p1_grant_Out,
    output logic               p2_grant_Out,
    output logic               timeout_Out,
    output logic [TIMER_W-1:0] timer_Out,
    output logic [MOVE_W-1:0]  movecount_Out
);

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        IDLE   = 3'd1,
        CLEAR  = 3'd2,
        TURN   = 3'd3,
        MOVE   = 3'd4,
        SWITCH = 3'd5,
        DONE   = 3'd6
    } stateType;

    localparam logic [1:0]         HOLD       = 2'b11;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TURN_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
    localparam logic [MOVE_W-1:0]  MOVE_MAX   = '1;

    stateType           stateReg, stateNext;
    logic               turnReg, turnNext;
    logic [TIMER_W-1:0] timerReg, timerNext;
    logic [MOVE_W-1:0]  moveCountReg, moveCountNext;
    logic [1:0]         latchReg, latchNext;
    logic               timeoutReg, timeoutNext;

    logic [1:0] reqVec [2];
    logic [1:0] grantVec;
    logic [1:0] grantedReq;
    logic       reqIsMove;

    assign reqVec[0] = p1_shiftselection_In;
    assign reqVec[1] = p2_shiftselection_In;

    // Player gi is granted only while waiting in TURN and it is its turn.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : genGrant
            assign grantVec[gi] = (stateReg == TURN) && (turnReg == (gi != 0));
        end
    endgenerate

    assign grantedReq = reqVec[turnReg];
    assign reqIsMove  = (grantedReq == 2'b01) || (grantedReq == 2'b10);

    always_ff @(posedge SC_STATEMACHINE_JUG1_CLOCK_50 or posedge SC_STATEMACHINE_JUG1_RESET_InHigh) begin
        if (SC_STATEMACHINE_JUG1_RESET_InHigh) begin
            stateReg     <= RESET;
            turnReg      <= 1'b0;
            timerReg     <= '0;
            moveCountReg <= '0;
            latchReg     <= HOLD;
            timeoutReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            turnReg      <= turnNext;
            timerReg     <= timerNext;
            moveCountReg <= moveCountNext;
            latchReg     <= latchNext;
            timeoutReg   <= timeoutNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        turnNext      = turnReg;
        timerNext     = timerReg;
        moveCountNext = moveCountReg;
        latchNext     = latchReg;
        timeoutNext   = timeoutReg;
        case (stateReg)
            RESET: stateNext = IDLE;
            IDLE: begin
                if (!startButton_InLow) stateNext = CLEAR;
            end
            CLEAR: begin
                timerNext     = TIMER_LOAD;
                turnNext      = 1'b0;
                moveCountNext = '0;
                timeoutNext   = 1'b0;
                stateNext     = TURN;
            end
            TURN: begin
                // Gameover beats a move, and a move beats an expiring tick.
                if (gameover_InHigh) begin
                    stateNext = DONE;
                end else if (reqIsMove) begin
                    latchNext   = grantedReq;
                    timeoutNext = 1'b0;
                    stateNext   = MOVE;
                end else if (tick_In && (timerReg == TIMER_ONE)) begin
                    timeoutNext = 1'b1;
                    stateNext   = SWITCH;
                end else if (tick_In) begin
                    timerNext = timerReg - TIMER_ONE;
                end
            end
            MOVE: begin
                if (moveCountReg != MOVE_MAX) moveCountNext = moveCountReg + 1'b1;
                stateNext = SWITCH;
            end
            SWITCH: begin
                turnNext    = ~turnReg;
                timerNext   = TIMER_LOAD;
                timeoutNext = 1'b0;
                stateNext   = TURN;
            end
            DONE: begin
                if (!startButton_InLow) stateNext = CLEAR;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        shiftselection_Out = (stateReg == MOVE) ? latchReg : HOLD;
        clear_OutLow       = (stateReg != CLEAR);
        p1_grant_Out       = grantVec[0];
        p2_grant_Out       = grantVec[1];
        timeout_Out        = (stateReg == SWITCH) && timeoutReg;
        turn_Out           = turnReg;
        timer_Out          = timerReg;
        movecount_Out      = moveCountReg;
    end

endmodule

// File: tb/tb_sc_game_turn_arbiter.sv
// Directed bench for sc_game_turn_arbiter: reference model of the game rules
// checked every cycle, plus literal expectations at key points.
module tb_sc_game_turn_arbiter;

    localparam int TT = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       startN = 1'b1;
    logic       go = 1'b0;
    logic [1:0] p1 = 2'b11;
    logic [1:0] p2 = 2'b11;

    logic [1:0] shiftOut;
    logic       clrN, turnOut, g1, g2, toOut;
    logic [3:0] timerOut;
    logic [7:0] movesOut;

    int total = 0;
    int bad   = 0;

    sc_game_turn_arbiter #(.TURN_TICKS(TT), .TIMER_W(4), .MOVE_W(8)) dut (
        .SC_STATEMACHINE_JUG1_CLOCK_50    (clk),
        .SC_STATEMACHINE_JUG1_RESET_InHigh(rst),
        .tick_In                          (tick),
        .startButton_InLow                (startN),
        .p1_shiftselection_In             (p1),
        .p2_shiftselection_In             (p2),
        .gameover_InHigh                  (go),
        .shiftselection_Out               (shiftOut),
        .clear_OutLow                     (clrN),
        .turn_Out                         (turnOut),
        .p1_grant_Out                     (g1),
        .p2_grant_Out                     (g2),
        .timeout_Out                      (toOut),
        .timer_Out                        (timerOut),
        .movecount_Out                    (movesOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Game model: phase 0 waiting after reset, 1 idle, 2 clearing, 3 in play, 4 over.
    // A turn ends with an overhead countdown: 2 = forwarding the move, 1 = handing over.
    int         ph = 0;
    int         overhead = 0;
    bit         toPend = 0;
    logic [1:0] mLatch = 2'b11;
    logic [1:0] mReq;
    bit         eTurn = 0;
    int         eTimer = 0;
    int         eMoves = 0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            ph = 0; overhead = 0; toPend = 0; mLatch = 2'b11;
            eTurn = 0; eTimer = 0; eMoves = 0;
        end else if (overhead > 0) begin
            if (overhead == 2) eMoves = (eMoves < 255) ? eMoves + 1 : 255;
            else begin
                eTurn = !eTurn; eTimer = TT; toPend = 0;
            end
            overhead--;
        end else begin
            case (ph)
                0: ph = 1;
                1, 4: if (!startN) ph = 2;
                2: begin eTimer = TT; eTurn = 0; eMoves = 0; ph = 3; end
                3: begin
                    mReq = eTurn ? p2 : p1;
                    if (go) ph = 4;
                    else if (mReq == 2'b01 || mReq == 2'b10) begin
                        mLatch = mReq; overhead = 2;
                    end else if (tick) begin
                        if (eTimer == 1) begin overhead = 1; toPend = 1; end
                        else eTimer--;
                    end
                end
                default: ph = 1;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("shift",   int'(shiftOut), (ph == 3 && overhead == 2) ? int'(mLatch) : 3);
        chk("clearN",  int'(clrN),     (ph == 2) ? 0 : 1);
        chk("turn",    int'(turnOut),  int'(eTurn));
        chk("grant1",  int'(g1),       (ph == 3 && overhead == 0 && !eTurn) ? 1 : 0);
        chk("grant2",  int'(g2),       (ph == 3 && overhead == 0 && eTurn) ? 1 : 0);
        chk("timeout", int'(toOut),    (overhead == 1 && toPend) ? 1 : 0);
        chk("timer",   int'(timerOut), eTimer);
        chk("moves",   int'(movesOut), eMoves);
    end

    initial begin
        #1 rst = 1'b1;
        step(2);
        chk("rst_shift", int'(shiftOut), 3);
        chk("rst_clr",   int'(clrN), 1);
        chk("rst_grant", int'({g1, g2}), 0);
        chk("rst_timer", int'(timerOut), 0);
        chk("rst_moves", int'(movesOut), 0);
        rst = 1'b0;
        step(2);

        // Start: start held low 3 cycles gives a single clear pulse
        startN = 1'b0;
        step(1);
        chk("start_clr", int'(clrN), 0);
        step(1);
        chk("start_clr_end", int'(clrN), 1);
        chk("start_turn",    int'(turnOut), 0);
        chk("start_g1",      int'(g1), 1);
        chk("start_timer",   int'(timerOut), 10);
        step(1);
        startN = 1'b1;

        // P1 moves left
        p1 = 2'b01;
        step(1);
        p1 = 2'b11;
        chk("mv_shift", int'(shiftOut), 1);
        step(1);
        chk("mv_moves", int'(movesOut), 1);
        chk("mv_shift_hold", int'(shiftOut), 3);
        step(1);
        chk("mv_turn",  int'(turnOut), 1);
        chk("mv_g2",    int'(g2), 1);
        chk("mv_timer", int'(timerOut), 10);

        // P2 times out after 10 ticks
        for (int k = 1; k <= TT; k++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            if (k < TT) chk("to_timer", int'(timerOut), TT - k);
            else        chk("to_pulse", int'(toOut), 1);
            step(1);
        end
        chk("to_turn",  int'(turnOut), 0);
        chk("to_moves", int'(movesOut), 1);
        chk("to_pulse_end", int'(toOut), 0);

        // Non-granted player is ignored
        p2 = 2'b10;
        step(3);
        p2 = 2'b11;
        chk("ign_shift", int'(shiftOut), 3);
        chk("ign_turn",  int'(turnOut), 0);

        // Move on the expiring tick wins over the timeout
        for (int k = 1; k < TT; k++) begin
            tick = 1'b1; step(1); tick = 1'b0; step(1);
        end
        chk("edge_timer", int'(timerOut), 1);
        p1 = 2'b10; tick = 1'b1;
        step(1);
        p1 = 2'b11; tick = 1'b0;
        chk("edge_shift", int'(shiftOut), 2);
        step(1);
        chk("edge_noto", int'(toOut), 0);
        step(1);
        chk("edge_turn", int'(turnOut), 1);

        // Gameover beats a simultaneous P2 move; DONE freezes everything
        p2 = 2'b01; go = 1'b1;
        step(1);
        p2 = 2'b11; go = 1'b0;
        chk("go_shift", int'(shiftOut), 3);
        chk("go_grant", int'({g1, g2}), 0);
        tick = 1'b1; p2 = 2'b01;
        step(1);
        tick = 1'b0; p2 = 2'b11;
        step(1);
        chk("done_timer", int'(timerOut), 10);
        chk("done_moves", int'(movesOut), 2);
        chk("done_turn",  int'(turnOut), 1);

        // Restart from DONE
        startN = 1'b0;
        step(1);
        chk("re_clr", int'(clrN), 0);
        startN = 1'b1;
        step(1);
        chk("re_turn",  int'(turnOut), 0);
        chk("re_moves", int'(movesOut), 0);

        // Asynchronous reset while a move is being forwarded
        p1 = 2'b01;
        step(1);
        p1 = 2'b11;
        chk("ar_shift_mv", int'(shiftOut), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_shift", int'(shiftOut), 3);
        chk("ar_moves", int'(movesOut), 0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("ar_idle_clr",   int'(clrN), 1);
        chk("ar_idle_grant", int'({g1, g2}), 0);
        startN = 1'b0;
        step(1);
        chk("ar_clr", int'(clrN), 0);
        startN = 1'b1;
        step(1);
        chk("ar_g1", int'(g1), 1);

        // Held requests re-execute every turn; move counter saturates
        p1 = 2'b01; p2 = 2'b10;
        step(3 * 260);
        p1 = 2'b11; p2 = 2'b11;
        step(3);
        chk("sat_moves", int'(movesOut), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
